uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Synthesizable UART receiver with a byte FIFO. It consumes the serial TX line of a UART
//   (e.g. UART0 RsTx) and exposes received bytes on a pop interface, so the LA/monitor logic
//   can capture firmware console output on-chip. 8N1 framing; LSB first.
// PARAMETERS
//   FIFO_DEPTH  16  entries in the byte FIFO; power of 2, 2..256
//   DIV_W       16  width of baud_div
// PORTS
//   HCLK       in   1             system clock
//   HRESET     in   1             synchronous reset, active-high
//   en         in   1             receiver enable; 0 forces the FSM to IDLE, FIFO contents retained
//   baud_div   in   DIV_W         HCLK cycles per bit; values <2 are treated as 2
//   rx         in   1             serial input, idle high, asynchronous
//   rd         in   1             pop head of FIFO (ignored when empty)
//   clr        in   1             clear overrun/frame_err/parity_err sticky flags
//   rdata      out  8             FIFO head (first-word fall-through); valid only when valid=1
//   valid      out  1             FIFO not empty
//   count      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   overrun    out  1             sticky: byte dropped because FIFO was full
//   frame_err  out  1             sticky: stop bit sampled low
//   parity_err out  1             sticky: parity mismatch (UART_RX_PARITY_EN only; else tied 0)
// BEHAVIOUR
// - Reset: valid=0, count=0, rdata=0, all sticky flags=0, FSM=IDLE, sync FFs=1, FIFO pointers=0.
// - rx passes through a 2-FF synchronizer (2-cycle latency); all sampling uses the sync output.
// - Bit counter reloads with baud_div; a sample point is reached when it counts down to 0.
// - FSM:
//   IDLE  : on sync falling edge (1->0) load half = baud_div>>1 -> START.
//   START : after half cycles sample; 0 -> DATA (load baud_div, bit_idx=0); 1 -> IDLE (glitch, no flags).
//   DATA  : sample every baud_div cycles into shift[bit_idx]; after bit 7 -> PARITY if enabled, else STOP.
//   PARITY: (macro only) one bit period; sample and compare.
//   STOP  : sample after baud_div cycles. 1 -> push byte, -> IDLE. 0 -> set frame_err, discard byte,
//           -> IDLE; a falling edge is not re-detected until sync rx has been seen high.
// - Push occurs in the cycle after the stop sample; valid/count update one cycle later.
// - Byte-to-valid latency: stop-bit midpoint + 1 cycle.
// - FIFO full and push with no rd: byte dropped, overrun=1, contents unchanged.
// - Full with push and rd in the same cycle: pop and push both succeed; count unchanged.
// - Empty with rd: ignored, no pointer change. Pointers wrap modulo FIFO_DEPTH.
// - clr and a new error in the same cycle: the flag is set (set wins).
// - en deasserted mid-frame: the partial byte is discarded, FSM goes to IDLE next cycle, no flags.
// - HRESET mid-frame: everything returns to reset values in the next cycle.
// - baud_div is sampled at START entry; a change mid-frame takes effect on the next frame.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: frame is 8E1. The PARITY state samples the even-parity bit.
//   On mismatch, parity_err=1 and the byte is still pushed if the stop bit is good.
// - UART_RX_PARITY_EN undefined: 8N1. No PARITY state; parity_err is constant 0.
// TESTING
// 1. HCLK=100MHz, baud_div=16 (160ns bit); send 0x41, 0x0A -> valid rises; rd pops 0x41 then
//    0x0A; count returns to 0.
// 2. Send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 and no rd -> count=16, overrun=1, reads yield
//    0x00..0x0F; clr -> overrun=0.
// 3. rx low pulse of 5 cycles at baud_div=16 -> START rejects it, no push, no flags.
// 4. Frame 0x55 with stop bit forced 0 -> frame_err=1, count=0; next good 0xA5 -> pushed, popped as 0xA5.
// 5. FIFO full plus a simultaneous rd and push -> count stays 16, overrun=0, and the new byte is last out.
// 6. Assert HRESET (or drop en) at bit 4 of a frame -> no push; next full frame 0x3C received correctly.
//    With UART_RX_PARITY_EN, send 0x03 with odd parity -> parity_err=1 and 0x03 still pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through
// byte FIFO. rx is synchronized internally; received bytes appear on rdata/valid and pop with rd.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr,
  output logic [7:0]                    rdata,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Receiver state
  logic             r_sync1, r_sync2, r_rx_prev;
  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic             r_push, w_push_nxt;
  logic             w_frame_set;
  logic             w_rx, w_fall, w_tick;
  logic [DIV_W-1:0] w_div_eff;

  // FIFO state
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun, r_frame_err;
  logic             w_full, w_do_push, w_do_pop, w_ovr_set;

  assign w_rx      = r_sync2;
  assign w_fall    = r_rx_prev & ~w_rx;
  assign w_tick    = (r_cnt == '0);
  assign w_div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;

`ifdef UART_RX_PARITY_EN
  logic r_parity_err, w_parity_set;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_push    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_push    <= w_push_nxt;
    end
  end

  // Counter is loaded with (period - 1) so each sample lands exactly one period after the last.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_push_nxt    = 1'b0;
    w_frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_set  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_div_nxt   = w_div_eff;
          w_cnt_nxt   = (w_div_eff >> 1) - DIV_W'(1);
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!w_rx) begin
            w_cnt_nxt     = r_div - DIV_W'(1);
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = S_DATA;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt[r_bit_idx] = w_rx;
          w_cnt_nxt              = r_div - DIV_W'(1);
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_parity_set = (w_rx != ^r_shift);
          w_cnt_nxt    = r_div - DIV_W'(1);
          w_state_nxt  = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_push_nxt  = w_rx;
          w_frame_set = ~w_rx;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Disabling the receiver abandons any frame in flight without raising flags.
    if (!en) begin
      w_state_nxt  = S_IDLE;
      w_push_nxt   = 1'b0;
      w_frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_parity_set = 1'b0;
`endif
    end
  end

  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = rd & (r_count != '0);
  assign w_do_push = r_push & (~w_full | w_do_pop);
  assign w_ovr_set = r_push & ~w_do_push;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // A new error outranks a clear arriving in the same cycle.
      r_overrun   <= (r_overrun & ~clr) | w_ovr_set;
      r_frame_err <= (r_frame_err & ~clr) | w_frame_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) r_parity_err <= 1'b0;
    else        r_parity_err <= (r_parity_err & ~clr) | w_parity_set;
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESET && w_do_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign valid     = (r_count != '0);
  assign rdata     = valid ? r_mem[r_rd_ptr] : 8'h00;
  assign count     = r_count;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are driven bit by bit and received bytes/flags are checked
// against a queue-based model of the FIFO and sticky flags. Honors UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic             HCLK = 1'b0;
  logic             HRESET, en, rx, rd, clr;
  logic [DIV_W-1:0] baud_div;
  logic [7:0]       rdata;
  logic             valid, overrun, frame_err, parity_err;
  logic [$clog2(DEPTH):0] count;
  logic [2:0]       dbg_state;

  logic [7:0] exp_q[$];
  logic       exp_ovr, exp_ferr, exp_perr;
  int         checks = 0;
  int         errors = 0;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .baud_div(baud_div), .rx(rx), .rd(rd), .clr(clr),
    .rdata(rdata), .valid(valid), .count(count), .overrun(overrun), .frame_err(frame_err),
    .parity_err(parity_err), .dbg_state(dbg_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},   32'(count), 32'(exp_q.size()));
    check({tag, "_valid"},   32'(valid), 32'(exp_q.size() != 0));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_ferr"},    32'(frame_err), 32'(exp_ferr));
    check({tag, "_perr"},    32'(parity_err), 32'(exp_perr));
  endtask

  // Model of one received frame: a bad stop bit discards, a full FIFO drops and flags overrun.
  task automatic deliver(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() > 0) begin
      check({tag, "_rdata"}, 32'(rdata), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_empty"}, 32'(valid), 32'(0));
    end
    rd = 1'b1;
    @(negedge HCLK);
    rd = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge HCLK);
    clr = 1'b0;
    exp_ovr = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
    @(negedge HCLK);
  endtask

  // rd_at_push pulses rd in the cycle the byte is written: stop sample is half a bit after the
  // synchronized stop-bit start, and the write follows one cycle later.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input logic rd_at_push);
    int bc, half;
    logic [10:0] bits;
    bc   = (baud_div < 2) ? 2 : int'(baud_div);
    half = bc >> 1;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = (^b) ^ par_flip;
    bits[NBITS-1] = stop_bit;
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      for (int c = 0; c < bc; c++) begin
        if (rd_at_push && i == NBITS-1) begin
          if (c == 3 + half) begin
            check("simul_head", 32'(rdata), 32'(exp_q[0]));
            rd = 1'b1;
          end else begin
            rd = 1'b0;
          end
        end
        @(negedge HCLK);
      end
    end
    rd = 1'b0;
    rx = 1'b1;
    repeat (6) @(negedge HCLK);
  endtask

  // Frame cut off during data bit 4 by either a reset pulse or en low.
  task automatic send_abort(input logic [7:0] b, input logic use_reset);
    int bc;
    bc = (baud_div < 2) ? 2 : int'(baud_div);
    rx = 1'b0;
    repeat (bc) @(negedge HCLK);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (bc) @(negedge HCLK);
    end
    rx = b[4];
    repeat (bc / 2) @(negedge HCLK);
    if (use_reset) begin
      HRESET = 1'b1;
      rx = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
    end else begin
      en = 1'b0;
      repeat (3) @(negedge HCLK);
      rx = 1'b1;
    end
    repeat (NBITS * bc) @(negedge HCLK);
    en = 1'b1;
    repeat (4) @(negedge HCLK);
  endtask

  initial begin
    logic [7:0] b;
    HRESET = 1'b1; en = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0; baud_div = 16;
    exp_ovr = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
    repeat (3) @(negedge HCLK);
    check_state("reset");
    check("reset_rdata", 32'(rdata), 32'(0));
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);

    // Two bytes in, two out in order
    send_frame(8'h41, 1'b1, 1'b0, 1'b0); deliver(8'h41, 1'b1);
    send_frame(8'h0A, 1'b1, 1'b0, 1'b0); deliver(8'h0A, 1'b1);
    check_state("two_bytes");
    pop_check("pop_41");
    pop_check("pop_0a");
    check_state("two_drained");

    // 17 bytes into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      deliver(8'(i), 1'b1);
    end
    check_state("overflow");
    for (int i = 0; i < 16; i++) pop_check("ovf_pop");
    pop_check("ovf_empty_rd");
    do_clr();
    check_state("ovf_clr");

    // Short low glitch is rejected by the start-bit check
    rx = 1'b0;
    repeat (5) @(negedge HCLK);
    rx = 1'b1;
    repeat (40) @(negedge HCLK);
    check_state("glitch");

    // Bad stop bit, then a good frame
    send_frame(8'h55, 1'b0, 1'b0, 1'b0); deliver(8'h55, 1'b0);
    check_state("bad_stop");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0); deliver(8'hA5, 1'b1);
    check_state("after_bad_stop");
    pop_check("pop_a5");
    do_clr();
    check_state("ferr_clr");

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, 1'b0);
      deliver(b, 1'b1);
    end
    check_state("full");
    send_frame(8'h77, 1'b1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    deliver(8'h77, 1'b1);
    check_state("full_simul");
    for (int i = 0; i < DEPTH; i++) pop_check("simul_drain");
    check_state("simul_drained");

    // Aborted frames: en drop keeps FIFO, reset clears it
    send_frame(8'h11, 1'b1, 1'b0, 1'b0); deliver(8'h11, 1'b1);
    send_abort(8'hE7, 1'b0);
    check_state("en_abort");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0); deliver(8'h3C, 1'b1);
    check_state("after_en_abort");
    send_abort(8'h6B, 1'b1);
    exp_q.delete();
    exp_ovr = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
    check_state("reset_abort");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0); deliver(8'h3C, 1'b1);
    check_state("after_reset_abort");
    pop_check("pop_3c");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    exp_perr = 1'b1;
    deliver(8'h03, 1'b1);
    check_state("parity_bad");
    pop_check("pop_03");
    do_clr();
    check_state("perr_clr");
`endif

    // Divider values below 2 behave as 2
    baud_div = 1;
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, 1'b0); deliver(b, 1'b1);
    baud_div = 0;
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, 1'b0); deliver(b, 1'b1);
    check_state("min_div");
    pop_check("min_div_pop1");
    pop_check("min_div_pop2");

    // Random bytes at random rates with random pops
    for (int i = 0; i < 16; i++) begin
      baud_div = DIV_W'($urandom_range(8, 40));
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, 1'b0);
      deliver(b, 1'b1);
      if ($urandom_range(0, 1) == 1) pop_check("rand_pop");
      check("rand_count", 32'(count), 32'(exp_q.size()));
    end
    while (exp_q.size() > 0) pop_check("rand_drain");
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
